// File: rtl/pc_sequencer.sv
// Program-counter owner and instruction-fetch sequencer for the multicycle core.
// Optional PC_PERF_CNT_EN adds saturating instr_cnt / taken_cnt performance counters.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
    parameter int          FETCH_TMO    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        fetch_valid,
    input  logic        resolve,
    input  logic        stall,
    input  logic [1:0]  branch_op,
    input  logic        cond,
    input  logic [15:0] imm16,
    input  logic [25:0] jidx,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [2:0]  pc_sel,
`ifdef PC_PERF_CNT_EN
    output logic [31:0] instr_cnt,
    output logic [31:0] taken_cnt,
`endif
    output logic        err
);
    localparam int TW = $clog2(FETCH_TMO + 1);

    typedef enum logic [1:0] {IDLE, FETCH, RESOLVE, HALT} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic [31:0]   target, br_off;
    logic          misaligned, apply, timeout;

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        target = pc_plus4;
        unique case (branch_op)
            2'b00: target = pc_plus4;
            2'b01: target = cond ? pc_plus4 + br_off : pc_plus4;
            2'b11: target = {pc_plus4[31:28], jidx, 2'b00};
            2'b10: target = jr_target;
        endcase
    end

    assign misaligned = (branch_op == 2'b10) && (jr_target[1:0] != 2'b00);
    assign apply      = (state == RESOLVE) && resolve && !stall;
    // ack in the same cycle as the last allowed wait cycle takes priority
    assign timeout    = (state == FETCH) && !imem_ack && (tmo_cnt == TW'(FETCH_TMO - 1));

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        unique case (state)
            IDLE:    state_nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack)     state_nxt = RESOLVE;
                else if (timeout) state_nxt = HALT;
            end
            RESOLVE: if (apply) state_nxt = misaligned ? HALT : FETCH;
            HALT:    state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            pc_sel      <= 3'b000;
            fetch_valid <= 1'b0;
            err         <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            fetch_valid <= (state == FETCH) && imem_ack;
            if (state != FETCH)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
            if (apply && !misaligned) begin
                pc     <= target;
                pc_sel <= {branch_op, cond};
            end
            if (timeout || (apply && misaligned))
                err <= 1'b1;
        end
    end

`ifdef PC_PERF_CNT_EN
    logic taken;
    assign taken = (target != pc_plus4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= '0;
            taken_cnt <= '0;
        end else if (apply && !misaligned) begin
            if (instr_cnt != 32'hFFFF_FFFF)
                instr_cnt <= instr_cnt + 32'd1;
            if (taken && taken_cnt != 32'hFFFF_FFFF)
                taken_cnt <= taken_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (works with or without PC_PERF_CNT_EN).
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ack, fetch_valid, resolve, stall, cond, err;
    logic [1:0]  branch_op;
    logic [15:0] imm16;
    logic [25:0] jidx;
    logic [31:0] jr_target, pc, pc_plus4;
    logic [2:0]  pc_sel;
`ifdef PC_PERF_CNT_EN
    logic [31:0] instr_cnt, taken_cnt;
`endif

    int cmp = 0;
    int mis = 0;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack),
        .fetch_valid(fetch_valid), .resolve(resolve), .stall(stall),
        .branch_op(branch_op), .cond(cond), .imm16(imm16), .jidx(jidx),
        .jr_target(jr_target), .pc(pc), .pc_plus4(pc_plus4), .pc_sel(pc_sel),
`ifdef PC_PERF_CNT_EN
        .instr_cnt(instr_cnt), .taken_cnt(taken_cnt),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; imem_ack = 0; resolve = 0; stall = 0; cond = 0;
        branch_op = 2'b00; imm16 = '0; jidx = '0; jr_target = '0;
        tick();
        rst_n = 1'b1;
        tick();   // IDLE -> FETCH
    endtask

    // One full instruction: wait for the request, ack it, then resolve.
    task automatic do_instr(input logic [1:0] op, input logic c, input logic [15:0] imm,
                            input logic [25:0] ji, input logic [31:0] jr);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin tick(); n++; end
        if (imem_req !== 1'b1) begin
            cmp++; mis++;
            $display("FAIL wait_req: imem_req=%b required 1", imem_req);
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        branch_op = op; cond = c; imm16 = imm; jidx = ji; jr_target = jr; resolve = 1'b1;
        tick();
        resolve = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 0; resolve = 0; stall = 0; cond = 0;
        branch_op = 2'b00; imm16 = '0; jidx = '0; jr_target = '0;
        tick();
        cmp++; if (pc !== 32'h0040_0000) begin mis++; $display("FAIL reset_pc: got %h want 00400000", pc); end
        cmp++; if (imem_req !== 1'b0) begin mis++; $display("FAIL reset_req: got %b want 0", imem_req); end
        cmp++; if ({fetch_valid, pc_sel, err} !== 5'b0) begin mis++; $display("FAIL reset_misc: got %b want 00000", {fetch_valid, pc_sel, err}); end
        rst_n = 1'b1;
        #1;
        cmp++; if (imem_req !== 1'b0) begin mis++; $display("FAIL release_req0: got %b want 0", imem_req); end
        tick();
        cmp++; if (imem_req !== 1'b1) begin mis++; $display("FAIL release_req1: got %b want 1", imem_req); end
    endtask

    task automatic test_seq();
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        cmp++; if ({fetch_valid, imem_req} !== 2'b10) begin mis++; $display("FAIL seq_fv: got fv,req=%b want 10", {fetch_valid, imem_req}); end
        branch_op = 2'b00; cond = 1'b0; resolve = 1'b1;
        tick();
        resolve = 1'b0;
        cmp++; if (pc !== 32'h0040_0004) begin mis++; $display("FAIL seq_pc: got %h want 00400004", pc); end
        cmp++; if (pc_sel !== 3'b000) begin mis++; $display("FAIL seq_sel: got %b want 000", pc_sel); end
        cmp++; if ({fetch_valid, imem_req} !== 2'b01) begin mis++; $display("FAIL seq_next: got fv,req=%b want 01", {fetch_valid, imem_req}); end
        cmp++; if (pc_plus4 !== 32'h0040_0008) begin mis++; $display("FAIL seq_pc4: got %h want 00400008", pc_plus4); end
    endtask

    task automatic test_branch();
        do_instr(2'b11, 1'b0, 16'h0, 26'h010_0004, 32'h0);
        cmp++; if (pc !== 32'h0040_0010) begin mis++; $display("FAIL br_setup: got %h want 00400010", pc); end
        do_instr(2'b01, 1'b1, 16'hFFFC, 26'h0, 32'h0);
        cmp++; if (pc !== 32'h0040_0004) begin mis++; $display("FAIL br_taken: got %h want 00400004", pc); end
        cmp++; if (pc_sel !== 3'b011) begin mis++; $display("FAIL br_sel: got %b want 011", pc_sel); end
        do_instr(2'b11, 1'b0, 16'h0, 26'h010_0004, 32'h0);
        do_instr(2'b01, 1'b0, 16'hFFFC, 26'h0, 32'h0);
        cmp++; if (pc !== 32'h0040_0014) begin mis++; $display("FAIL br_not: got %h want 00400014", pc); end
        cmp++; if (pc_sel !== 3'b010) begin mis++; $display("FAIL br_not_sel: got %b want 010", pc_sel); end
    endtask

    task automatic test_jump();
        apply_reset();
        do_instr(2'b11, 1'b0, 16'h0, 26'h010_0010, 32'h0);
        cmp++; if (pc !== 32'h0040_0040) begin mis++; $display("FAIL j_pc: got %h want 00400040", pc); end
        cmp++; if (pc_sel !== 3'b110) begin mis++; $display("FAIL j_sel: got %b want 110", pc_sel); end
        do_instr(2'b10, 1'b0, 16'h0, 26'h0, 32'h0040_0002);
        cmp++; if (err !== 1'b1) begin mis++; $display("FAIL jr_err: got %b want 1", err); end
        cmp++; if (pc !== 32'h0040_0040) begin mis++; $display("FAIL jr_pc: got %h want 00400040", pc); end
        imem_ack = 1'b1;
        repeat (3) tick();
        imem_ack = 1'b0;
        cmp++; if ({imem_req, fetch_valid} !== 2'b00) begin mis++; $display("FAIL halt_req: got req,fv=%b want 00", {imem_req, fetch_valid}); end
    endtask

    task automatic test_wrap_stall();
        apply_reset();
        do_instr(2'b10, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        cmp++; if (pc !== 32'hFFFF_FFFC) begin mis++; $display("FAIL jr_pc: got %h want fffffffc", pc); end
        do_instr(2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
        cmp++; if (pc !== 32'h0000_0000) begin mis++; $display("FAIL wrap_pc: got %h want 00000000", pc); end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        branch_op = 2'b00; resolve = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp++; if ({pc, imem_req} !== {32'h0, 1'b0}) begin mis++; $display("FAIL stall_hold%0d: got pc=%h req=%b want 0/0", i, pc, imem_req); end
        end
        stall = 1'b0;
        tick();
        resolve = 1'b0;
        cmp++; if (pc !== 32'h0000_0004) begin mis++; $display("FAIL stall_release: got %h want 00000004", pc); end
`ifdef PC_PERF_CNT_EN
        cmp++; if ({instr_cnt, taken_cnt} !== {32'd3, 32'd1}) begin mis++; $display("FAIL perf_cnt: got %0d/%0d want 3/1", instr_cnt, taken_cnt); end
`endif
    endtask

    task automatic test_timeout();
        apply_reset();
        repeat (15) tick();
        cmp++; if ({err, imem_req} !== 2'b01) begin mis++; $display("FAIL tmo_early: got err,req=%b want 01", {err, imem_req}); end
        tick();
        cmp++; if ({err, imem_req} !== 2'b10) begin mis++; $display("FAIL tmo_fire: got err,req=%b want 10", {err, imem_req}); end
        apply_reset();
        repeat (15) tick();
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        cmp++; if ({err, fetch_valid} !== 2'b01) begin mis++; $display("FAIL ack_wins: got err,fv=%b want 01", {err, fetch_valid}); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_instr(2'b11, 1'b1, 16'h0, 26'h010_0010, 32'h0);
        cmp++; if ({pc, imem_req} !== {32'h0040_0040, 1'b1}) begin mis++; $display("FAIL mid_setup: got pc=%h req=%b want 00400040/1", pc, imem_req); end
        rst_n = 1'b0;
        #1;
        cmp++; if ({pc, imem_req, fetch_valid, pc_sel, err} !== {32'h0040_0000, 5'b0, 1'b0}) begin
            mis++; $display("FAIL mid_reset: got pc=%h req=%b fv=%b sel=%b err=%b want 00400000/0/0/000/0", pc, imem_req, fetch_valid, pc_sel, err);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_jump();
        test_wrap_stall();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule
